uart_hex_sender: RTL and testbench

- Transmit-side counterpart to the UART receive/seven-segment display path.
- Accepts one byte on a single-cycle strobe and sends it over UART as two ASCII hex characters, high nibble first (for example, 0x3C is sent as "3C").
- Sits between on-board byte sources (switch, counter or echo logic) and the o_UART_TX pin.
- Serial format is 8N1: LSB first, idle high.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_engine.sv | 121 ++++++++++++
 rtl/uart_hex_sender.sv | 131 +++++++++++++
 tb/tb_uart_hex_sender.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART hex sender: ASCII constants, FSM state types, nibble mapping.
// Optional CR/LF states exist only when UART_HEX_SENDER_CRLF_EN is defined.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_SEND_HI = 3'd1,
    SEQ_SEND_LO = 3'd2,
`ifdef UART_HEX_SENDER_CRLF_EN
    SEQ_SEND_CR = 3'd3,
    SEQ_SEND_LF = 3'd4,
`endif
    SEQ_FINISH  = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] chr;
    if (nib < 4'd10) begin
      chr = ASCII_ZERO + {4'h0, nib};
    end else begin
      chr = ASCII_UPPER_A + {4'h0, nib} - 8'd10;
    end
    return chr;
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PEN_CNT  = CW'(CLKS_PER_BIT - 2);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  // Next-state logic; done is raised for the final clock of the stop bit so the
  // sequencer can act on the very edge at which the line becomes free.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d    = '0;
        idx_d    = 3'd0;
        serial_d = 1'b1;
        if (i_TX_DV) begin
          data_d   = i_TX_Byte;
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = TX_START;
        end else begin
          active_d = 1'b0;
        end
      end
      TX_START: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          serial_d = data_q[0];
          state_d  = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d    = 3'd0;
            serial_d = 1'b1;
            state_d  = TX_STOP;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = data_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = TX_IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          done_d = (cnt_q == PEN_CNT);
        end
      end
      default: begin
        cnt_d    = '0;
        idx_d    = 3'd0;
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = TX_IDLE;
      end
    endcase
  end

  // State and output registers; the line idles high out of reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      data_q   <= 8'h00;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_TX_Active = active_q;
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;

endmodule

// File: rtl/uart_hex_sender.sv
// Sends a strobed byte as two uppercase ASCII hex characters over UART (high nibble first).
// Define UART_HEX_SENDER_CRLF_EN to append CR and LF after the two hex characters.
module uart_hex_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_Byte,
  input  logic       i_Byte_DV,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_UART_TX
);

  seq_state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tx_dv_s;
  logic [7:0] tx_byte_s;
  logic       tx_active_s;
  logic       tx_done_s;

  // Sequencer: the first character is handed to the engine on the accepting edge
  // itself; later characters are loaded in the first (idle) clock of their state.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_dv_s   = 1'b0;
    tx_byte_s = 8'h00;
    case (state_q)
      SEQ_IDLE, SEQ_FINISH: begin
        if (i_Byte_DV) begin
          byte_d    = i_Byte;
          busy_d    = 1'b1;
          tx_dv_s   = 1'b1;
          tx_byte_s = nibble_to_ascii(i_Byte[7:4]);
          state_d   = SEQ_SEND_HI;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_SEND_HI: begin
        if (tx_done_s) begin
          state_d = SEQ_SEND_LO;
        end else begin
          state_d = SEQ_SEND_HI;
        end
      end
      SEQ_SEND_LO: begin
        tx_byte_s = nibble_to_ascii(byte_q[3:0]);
        if (!tx_active_s) begin
          tx_dv_s = 1'b1;
        end else if (tx_done_s) begin
`ifdef UART_HEX_SENDER_CRLF_EN
          state_d = SEQ_SEND_CR;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = SEQ_FINISH;
`endif
        end else begin
          state_d = SEQ_SEND_LO;
        end
      end
`ifdef UART_HEX_SENDER_CRLF_EN
      SEQ_SEND_CR: begin
        tx_byte_s = ASCII_CR;
        if (!tx_active_s) begin
          tx_dv_s = 1'b1;
        end else if (tx_done_s) begin
          state_d = SEQ_SEND_LF;
        end else begin
          state_d = SEQ_SEND_CR;
        end
      end
      SEQ_SEND_LF: begin
        tx_byte_s = ASCII_LF;
        if (!tx_active_s) begin
          tx_dv_s = 1'b1;
        end else if (tx_done_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = SEQ_FINISH;
        end else begin
          state_d = SEQ_SEND_LF;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // Sequencer state, latched byte and handshake output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= SEQ_IDLE;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_engine (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_TX_Byte  (tx_byte_s),
    .i_TX_DV    (tx_dv_s),
    .o_TX_Active(tx_active_s),
    .o_TX_Serial(o_UART_TX),
    .o_TX_Done  (tx_done_s)
  );

  assign o_Busy = busy_q;
  assign o_Done = done_q;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed-vector bench for uart_hex_sender at CLKS_PER_BIT=4; decodes the serial line bit by bit.
module tb_uart_hex_sender;

  localparam int CPB = 4;
`ifdef UART_HEX_SENDER_CRLF_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 2;
`endif
  localparam int SEQ_CLKS = NCH * 10 * CPB + NCH - 1;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       dv      = 1'b0;
  logic       busy;
  logic       done;
  logic       tx;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_hex_sender #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_Clk    (clk),
    .i_Rst_L  (rst_n),
    .i_Byte   (byte_in),
    .i_Byte_DV(dv),
    .o_Busy   (busy),
    .o_Done   (done),
    .o_UART_TX(tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle strobe; returns just after the accepting edge, with i_Byte scrambled.
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    byte_in = b;
    dv      = 1'b1;
    @(posedge clk);
    #1;
    dv      = 1'b0;
    byte_in = ~b;
  endtask

  task automatic rx_char(output logic [7:0] c, output int t0);
    int w;
    w  = 0;
    c  = 8'h00;
    t0 = -1;
    @(negedge clk);
    while (tx !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      check_val("rx_start_timeout", 64'd1, 64'd0);
      return;
    end
    t0 = cyc;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (CPB) @(negedge clk);
      c[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    check_val("stop_bit", {63'd0, tx}, 64'd1);
  endtask

  task automatic wait_done(output int t);
    int w;
    w = 0;
    while (done !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (done !== 1'b1) check_val("done_timeout", 64'd1, 64'd0);
    t = cyc;
  endtask

  // Receive the remaining characters of a sequence (index from..NCH-1) and its done pulse.
  task automatic rx_rest(input logic [7:0] e_lo, input int from, input int t_first, input int t_prev_in);
    logic [7:0] exp_c [4];
    logic [7:0] c;
    int t0, tprev, td;
    exp_c[0] = 8'h00;
    exp_c[1] = e_lo;
    exp_c[2] = 8'h0D;
    exp_c[3] = 8'h0A;
    tprev = t_prev_in;
    for (int i = from; i < NCH; i++) begin
      rx_char(c, t0);
      check_val("char", {56'd0, c}, {56'd0, exp_c[i]});
      check_val("char_gap", 64'(t0 - tprev), 64'(10 * CPB + 1));
      tprev = t0;
    end
    wait_done(td);
    check_val("done_latency", 64'(td - t_first), 64'(SEQ_CLKS));
    check_val("busy_at_done", {63'd0, busy}, 64'd0);
    check_val("tx_idle_at_done", {63'd0, tx}, 64'd1);
    @(negedge clk);
    check_val("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic run_seq(input logic [7:0] b, input logic [7:0] e_hi, input logic [7:0] e_lo);
    logic [7:0] c;
    int t0;
    strobe(b);
    rx_char(c, t0);
    check_val("char_hi", {56'd0, c}, {56'd0, e_hi});
    rx_rest(e_lo, 1, t0, t0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic        quiet;
    logic [39:0] wave, exp_wave;
    logic [9:0]  frame;
    logic [7:0]  c;
    int          t0, t1, td;

    // Reset state and idle line
    repeat (3) @(negedge clk);
    check_val("rst_tx", {63'd0, tx}, 64'd1);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    quiet = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet = 1'b1;
    end
    check_val("idle_quiet", {63'd0, quiet}, 64'd0);

    // 0x3C: exact waveform of "3" then "C"
    frame = {1'b1, 8'h33, 1'b0};
    strobe(8'h3C);
    t0 = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) begin
        t0 = cyc;
        check_val("busy_at_start", {63'd0, busy}, 64'd1);
      end
      wave[j]     = tx;
      exp_wave[j] = frame[j / 4];
    end
    check_val("frame0_wave", {24'd0, wave}, {24'd0, exp_wave});
    rx_rest(8'h43, 1, t0, t0);
    repeat (3) @(negedge clk);

    run_seq(8'h00, 8'h30, 8'h30);
    run_seq(8'hFF, 8'h46, 8'h46);
    run_seq(8'hA5, 8'h41, 8'h35);

    // Strobe while busy is dropped; strobe during done cycle is accepted
    strobe(8'h12);
    fork
      rx_char(c, t1);
      begin
        repeat (10) @(negedge clk);
        byte_in = 8'h34;
        dv      = 1'b1;
        @(posedge clk);
        #1;
        dv = 1'b0;
      end
    join
    check_val("drop_hi", {56'd0, c}, 64'h31);
    rx_char(c, t0);
    check_val("drop_lo", {56'd0, c}, 64'h32);
    for (int i = 2; i < NCH; i++) rx_char(c, t0);
    wait_done(td);
    check_val("drop_done_latency", 64'(td - t1), 64'(SEQ_CLKS));
    byte_in = 8'h56;
    dv      = 1'b1;
    @(posedge clk);
    #1;
    dv = 1'b0;
    rx_char(c, t0);
    check_val("b2b_gap", 64'(t0 - td), 64'd1);
    check_val("b2b_hi", {56'd0, c}, 64'h35);
    rx_rest(8'h36, 1, t0, t0);
    repeat (3) @(negedge clk);

    // Asynchronous reset during a data bit, then clean restart
    strobe(8'h00);
    repeat (6) @(negedge clk);
    check_val("pre_reset_low", {63'd0, tx}, 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_tx", {63'd0, tx}, 64'd1);
    check_val("async_rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b1;
    end
    check_val("post_rst_quiet", {63'd0, quiet}, 64'd0);
    run_seq(8'h7E, 8'h37, 8'h45);

`ifdef UART_HEX_SENDER_CRLF_EN
    run_seq(8'h9B, 8'h39, 8'h42);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
